// File: rtl/data_memory_lsu_pkg.sv
// rtl/data_memory_lsu_pkg.sv - shared funct3 encodings and lane constants for the data memory LSU
package data_memory_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int BE_W = 4;

    function automatic logic is_legal_load(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic is_legal_store(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    endfunction

endpackage

// File: rtl/data_memory_lsu_load_extend.sv
// rtl/data_memory_lsu_load_extend.sv - lane selection and sign/zero extension of load data
module lsu_load_extend
    import data_memory_lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_sel,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        byte_val = word[8*byte_sel +: 8];
        half_val = byte_sel[1] ? word[31:16] : word[15:0];
        result   = '0;
        case (funct3)
            F3_B:    result = {{24{byte_val[7]}}, byte_val};
            F3_H:    result = {{16{half_val[15]}}, half_val};
            F3_W:    result = word;
            F3_BU:   result = {24'b0, byte_val};
            F3_HU:   result = {16'b0, half_val};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_lsu.sv
// rtl/data_memory_lsu.sv - single-cycle data memory with byte-lane stores, extended loads and fault status
module data_memory_lsu
    import data_memory_lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [2:0]       funct3,
    input  logic [31:0]      addr,
    input  logic [31:0]      write_data,
    output logic [31:0]      read_data,
    output logic             misaligned,
    output logic             fault_sticky,
    output logic [CNT_W-1:0] store_count
);

    localparam int IDX = $clog2(DEPTH_WORDS);

    logic [31:0]     mem [DEPTH_WORDS];
    logic [IDX-1:0]  word_idx;
    logic            in_range;
    logic            align_bad;
    logic            load_fault;
    logic            store_fault;
    logic            access_fault;
    logic            commit;
    logic [BE_W-1:0] byte_en;
    logic [31:0]     lane_data;
    logic [31:0]     load_ext;

    assign word_idx = addr[IDX+1:2];
    assign in_range = (addr[31:IDX+2] == '0);

    // Alignment follows the access size encoded in funct3[1:0].
    always_comb begin
        align_bad = 1'b0;
        case (funct3[1:0])
            2'b01:   align_bad = addr[0];
            2'b10:   align_bad = |addr[1:0];
            default: align_bad = 1'b0;
        endcase
    end

    assign misaligned   = (mem_read | mem_write) & align_bad;
    assign load_fault   = !is_legal_load(funct3) | align_bad | !in_range;
    assign store_fault  = !is_legal_store(funct3) | align_bad | !in_range;
    assign access_fault = (mem_read & load_fault) | (mem_write & store_fault);
    assign commit       = mem_write & !store_fault & !reset;

    // Replicate store data across lanes so each enabled lane takes its own slice.
    always_comb begin
        byte_en   = '0;
        lane_data = write_data;
        case (funct3)
            F3_B: begin
                byte_en   = BE_W'(1) << addr[1:0];
                lane_data = {4{write_data[7:0]}};
            end
            F3_H: begin
                byte_en   = addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{write_data[15:0]}};
            end
            F3_W: begin
                byte_en   = 4'b1111;
                lane_data = write_data;
            end
            default: begin
                byte_en   = '0;
                lane_data = write_data;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (commit && byte_en[i]) begin
                mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_sticky <= 1'b0;
            store_count  <= '0;
        end else begin
            if (commit) begin
                store_count <= store_count + CNT_W'(1);
            end
            if (access_fault) begin
                fault_sticky <= 1'b1;
            end
        end
    end

    lsu_load_extend u_load_extend (
        .word     (mem[word_idx]),
        .byte_sel (addr[1:0]),
        .funct3   (funct3),
        .result   (load_ext)
    );

    assign read_data = (mem_read && !load_fault) ? load_ext : 32'h0;

endmodule

// File: tb/tb_data_memory_lsu.sv
// tb/tb_data_memory_lsu.sv - directed self-checking bench for data_memory_lsu
module tb_data_memory_lsu;
    import data_memory_lsu_pkg::*;

    localparam int DEPTH_WORDS = 256;
    localparam int CNT_W       = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             mem_read;
    logic             mem_write;
    logic [2:0]       funct3;
    logic [31:0]      addr;
    logic [31:0]      write_data;
    logic [31:0]      read_data;
    logic             misaligned;
    logic             fault_sticky;
    logic [CNT_W-1:0] store_count;

    int checks   = 0;
    int failures = 0;

    data_memory_lsu #(.DEPTH_WORDS(DEPTH_WORDS), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .funct3       (funct3),
        .addr         (addr),
        .write_data   (write_data),
        .read_data    (read_data),
        .misaligned   (misaligned),
        .fault_sticky (fault_sticky),
        .store_count  (store_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        mem_read   = r;
        mem_write  = w;
        funct3     = f3;
        addr       = a;
        write_data = d;
        #1;
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        drive(1'b0, 1'b1, f3, a, d);
        step();
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
    endtask

    task automatic load_check(input string tag, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] exp);
        drive(1'b1, 1'b0, f3, a, 32'h0);
        check(tag, read_data, exp);
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_fault_now", 32'(fault_sticky), 32'h0);
        check("rst_count_now", 32'(store_count), 32'h0);
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        step();
        step();
        check("reset_fault", 32'(fault_sticky), 32'h0);
        check("reset_count", 32'(store_count), 32'h0);
        reset = 1'b0;
        step();

        store(F3_W, 32'h10, 32'hDEADBEEF);
        load_check("t1_lw", F3_W, 32'h10, 32'hDEADBEEF);
        check("t1_count", 32'(store_count), 32'h1);

        store(F3_B, 32'h11, 32'h12345680);
        load_check("t2_lb", F3_B, 32'h11, 32'hFFFFFF80);
        load_check("t2_lbu", F3_BU, 32'h11, 32'h00000080);
        load_check("t2_lw", F3_W, 32'h10, 32'hDEAD80EF);
        load_check("t2_lh_hi", F3_H, 32'h12, 32'hFFFFDEAD);
        load_check("t2_lhu_lo", F3_HU, 32'h10, 32'h000080EF);
        load_check("t2_no_read", F3_W, 32'h10, 32'hDEAD80EF);
        drive(1'b0, 1'b0, F3_W, 32'h10, 32'h0);
        check("t2_read_idle", read_data, 32'h0);
        check("t2_fault_clean", 32'(fault_sticky), 32'h0);

        drive(1'b0, 1'b1, F3_H, 32'h13, 32'h0000CAFE);
        check("t3_misaligned", 32'(misaligned), 32'h1);
        step();
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        check("t3_fault", 32'(fault_sticky), 32'h1);
        check("t3_count", 32'(store_count), 32'h2);
        load_check("t3_word", F3_W, 32'h10, 32'hDEAD80EF);
        drive(1'b1, 1'b0, F3_W, 32'h12, 32'h0);
        check("t3_lw_mis_flag", 32'(misaligned), 32'h1);
        check("t3_lw_mis_data", read_data, 32'h0);
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);

        reset_pulse();
        drive(1'b1, 1'b0, F3_W, 32'h400, 32'h0);
        check("t4_oor_data", read_data, 32'h0);
        check("t4_oor_mis", 32'(misaligned), 32'h0);
        step();
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        check("t4_oor_fault", 32'(fault_sticky), 32'h1);
        reset_pulse();
        check("t4_fault_clr", 32'(fault_sticky), 32'h0);
        check("t4_count_clr", 32'(store_count), 32'h0);

        store(F3_W, 32'h20, 32'h11111111);
        store(F3_BU, 32'h24, 32'h55555555);
        check("ill_store_fault", 32'(fault_sticky), 32'h1);
        check("ill_store_count", 32'(store_count), 32'h1);
        store(F3_W, 32'h400, 32'h77777777);
        check("oor_store_count", 32'(store_count), 32'h1);

        @(posedge clk);
        #1;
        mem_write  = 1'b1;
        funct3     = F3_W;
        addr       = 32'h20;
        write_data = 32'h12345678;
        #2;
        reset = 1'b1;
        #1;
        check("t5_fault_async", 32'(fault_sticky), 32'h0);
        check("t5_count_async", 32'(store_count), 32'h0);
        step();
        reset = 1'b0;
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        load_check("t5_not_written", F3_W, 32'h20, 32'h11111111);

        for (int i = 0; i < (1 << CNT_W) - 1; i++) begin
            store(F3_W, 32'h30, 32'(i));
        end
        check("t6_count_full", 32'(store_count), 32'hFF);
        drive(1'b1, 1'b1, F3_W, 32'h30, 32'hAAAA5555);
        check("t6_rw_old", read_data, 32'h000000FE);
        step();
        mem_write = 1'b0;
        #1;
        check("t6_count_wrap", 32'(store_count), 32'h0);
        check("t6_rw_new", read_data, 32'hAAAA5555);
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        check("t6_fault_clean", 32'(fault_sticky), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
